// File: rtl/dut_resp_capture.sv
// Capture stage for the 20-in/10-out combinational dut: drives stimulus, samples the settled
// response into a FWFT FIFO, counts captures. MISR signature enabled by DUT_RESP_CAPTURE_MISR_EN.
module dut_resp_capture #(
  parameter int SETTLE = 1,
  parameter int DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stim_valid,
  input  logic [19:0] stim_data,
  output logic        stim_ready,
  output logic [19:0] dut_in,
  input  logic [9:0]  dut_out,
  output logic        res_valid,
  output logic [9:0]  res_data,
  input  logic        res_ready,
  input  logic        clr,
  output logic [9:0]  signature,
  output logic [15:0] vec_count,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and ready may depend on internal state only.
  typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      settle_cnt_q, settle_cnt_d;
  logic [19:0]     dut_in_q, dut_in_d;
  logic            ready_en_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     vec_count_q, vec_count_d;
  logic [9:0]      mem_q [DEPTH];
  logic            push;
  logic            pop;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    dut_in_d     = dut_in_q;
    push         = 1'b0;
    stim_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A free slot is reserved here, so the capture can never meet a full FIFO.
        stim_ready = ready_en_q && (count_q < CW'(DEPTH));
        if (stim_valid && stim_ready) begin
          dut_in_d     = stim_data;
          settle_cnt_d = 4'(SETTLE);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 4'd1) begin
          push         = 1'b1;
          settle_cnt_d = 4'd0;
          state_d      = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = (count_q != '0) && res_ready;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    vec_count_d = vec_count_q;
    if (clr)       vec_count_d = 16'h0000;
    else if (push) vec_count_d = vec_count_q + 16'h0001;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 4'd0;
      dut_in_q     <= 20'h00000;
      ready_en_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      vec_count_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      dut_in_q     <= dut_in_d;
      ready_en_q   <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      vec_count_q  <= vec_count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dut_out;
  end

`ifdef DUT_RESP_CAPTURE_MISR_EN
  logic [9:0] sig_q, sig_d;

  // x^10 + x^3 + 1: the shifted-out bit feeds back into taps 3 and 0.
  always_comb begin
    sig_d = sig_q;
    if (clr)       sig_d = 10'h000;
    else if (push) sig_d = ({sig_q[8:0], 1'b0} ^ (sig_q[9] ? 10'h009 : 10'h000)) ^ dut_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 10'h000;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = 10'h000;
`endif

  assign dut_in    = dut_in_q;
  assign res_valid = (count_q != '0);
  assign res_data  = res_valid ? mem_q[rd_ptr_q] : 10'h000;
  assign vec_count = vec_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dut_resp_capture.sv
// Bench for dut_resp_capture: scoreboard on the result FIFO plus a reference model of
// the capture count and MISR signature; a second instance covers SETTLE=4 and mid-settle reset.
module tb_dut_resp_capture;

  localparam int SETTLE_A = 1;
  localparam int DEPTH_A  = 8;
  localparam int SETTLE_B = 4;
  localparam int DEPTH_B  = 4;

  logic        clk = 1'b0;
  logic        rst, stim_valid, stim_ready, res_valid, res_ready, clr, busy;
  logic [19:0] stim_data, dut_in;
  logic [9:0]  dut_out, res_data, signature;
  logic [15:0] vec_count;

  logic        b_rst, b_stim_valid, b_stim_ready, b_res_valid, b_res_ready, b_clr, b_busy;
  logic [19:0] b_stim_data, b_dut_in, b_prev;
  logic [9:0]  b_dut_out, b_res_data, b_signature;
  logic [15:0] b_vec_count;
  int          b_age;

  logic [9:0]  exp_q[$];
  logic [9:0]  m_sig;
  logic [15:0] m_cnt;
  bit          rand_pop_en;
  int          checks, errors;

  always #5 clk = ~clk;

  // Stand-in for the combinational dut.
  function automatic logic [9:0] dut_model(input logic [19:0] x);
    logic [9:0] lo, hi;
    lo = x[9:0];
    hi = x[19:10];
    return ~(lo ^ hi);
  endfunction

  // Signature = previous signature times x, reduced mod x^10+x^3+1, plus the captured word.
  function automatic logic [9:0] misr_next(input logic [9:0] s, input logic [9:0] v);
    logic [10:0] t;
    t = {s, 1'b0};
    if (t[10]) t = t ^ 11'h409;
    return t[9:0] ^ v;
  endfunction

  function automatic logic [9:0] exp_sig(input logic [9:0] s);
`ifdef DUT_RESP_CAPTURE_MISR_EN
    return s;
`else
    return 10'h000 & s;
`endif
  endfunction

  assign dut_out   = dut_model(dut_in);
  // Response settles SETTLE_B-1 cycles after dut_in changes; earlier samples see garbage.
  assign b_dut_out = (b_age >= SETTLE_B - 1) ? dut_model(b_dut_in) : ~dut_model(b_dut_in);

  dut_resp_capture #(.SETTLE(SETTLE_A), .DEPTH(DEPTH_A)) u_dut (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .stim_data(stim_data),
    .stim_ready(stim_ready), .dut_in(dut_in), .dut_out(dut_out), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .clr(clr), .signature(signature),
    .vec_count(vec_count), .busy(busy)
  );

  dut_resp_capture #(.SETTLE(SETTLE_B), .DEPTH(DEPTH_B)) u_dut_b (
    .clk(clk), .rst(b_rst), .stim_valid(b_stim_valid), .stim_data(b_stim_data),
    .stim_ready(b_stim_ready), .dut_in(b_dut_in), .dut_out(b_dut_out), .res_valid(b_res_valid),
    .res_data(b_res_data), .res_ready(b_res_ready), .clr(b_clr), .signature(b_signature),
    .vec_count(b_vec_count), .busy(b_busy)
  );

  always @(negedge clk) begin
    if (b_dut_in != b_prev) begin
      b_age  = 0;
      b_prev = b_dut_in;
    end else if (b_age < 15) begin
      b_age = b_age + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge whenever valid & ready are seen mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %h expected none", res_data);
        end else begin
          check("res_data_pop", {22'h0, res_data}, {22'h0, exp_q.pop_front()});
        end
      end else if (!res_valid) begin
        check("res_data_idle_zero", {22'h0, res_data}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_pop_en) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [19:0] d, input bit clr_cap, input bit pop_cap);
    int n;
    logic [9:0] v;
    stim_valid = 1'b1;
    stim_data  = d;
    n = 0;
    while (!stim_ready && n < 100) begin
      tick();
      n++;
    end
    if (!stim_ready) begin
      check("accept_timeout", 32'h0, 32'h1);
      stim_valid = 1'b0;
      return;
    end
    v = dut_model(d);
    exp_q.push_back(v);
    tick();
    stim_valid = 1'b0;
    check("dut_in_after_accept", {12'h0, dut_in}, {12'h0, d});
    check("busy_in_settle", {31'h0, busy}, 32'h1);
    repeat (SETTLE_A - 1) tick();
    if (clr_cap) clr = 1'b1;
    if (pop_cap) res_ready = 1'b1;
    tick();
    clr = 1'b0;
    if (pop_cap && !rand_pop_en) res_ready = 1'b0;
    if (clr_cap) begin
      m_sig = 10'h000;
      m_cnt = 16'h0000;
    end else begin
      m_sig = misr_next(m_sig, v);
      m_cnt = m_cnt + 16'h0001;
    end
    check("signature", {22'h0, signature}, {22'h0, exp_sig(m_sig)});
    check("vec_count", {16'h0, vec_count}, {16'h0, m_cnt});
    check("busy_after_capture", {31'h0, busy}, 32'h0);
  endtask

  task automatic drain();
    int n;
    rand_pop_en = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (res_valid && n < 100) begin
      tick();
      n++;
    end
    res_ready = 1'b0;
    check("drain_empty", {31'h0, res_valid}, 32'h0);
    check("scoreboard_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] d9;
    int n;
    checks = 0; errors = 0; rand_pop_en = 1'b0;
    m_sig = 10'h000; m_cnt = 16'h0000;
    b_age = 0; b_prev = 20'h0;
    rst = 1'b1; stim_valid = 1'b0; stim_data = 20'h0; res_ready = 1'b0; clr = 1'b0;
    b_rst = 1'b1; b_stim_valid = 1'b0; b_stim_data = 20'h0; b_res_ready = 1'b0; b_clr = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim_ready", {31'h0, stim_ready}, 32'h0);
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_dut_in", {12'h0, dut_in}, 32'h0);
    check("rst_res_data", {22'h0, res_data}, 32'h0);
    check("rst_signature", {22'h0, signature}, 32'h0);
    check("rst_vec_count", {16'h0, vec_count}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_rst = 1'b0;
    tick();
    check("ready_after_release", {31'h0, stim_ready}, 32'h1);
    check("busy_after_release", {31'h0, busy}, 32'h0);

    // Single vector, then MISR chaining
    send(20'h00000, 1'b0, 1'b0);
    check("single_res_valid", {31'h0, res_valid}, 32'h1);
    check("single_res_data", {22'h0, res_data}, 32'h3FF);
    check("single_dut_in_held", {12'h0, dut_in}, 32'h0);
    send(20'h003FF, 1'b0, 1'b0);
    check("chain_vec_count", {16'h0, vec_count}, 32'h2);
`ifdef DUT_RESP_CAPTURE_MISR_EN
    check("chain_signature", {22'h0, signature}, 32'h3F7);
`else
    check("chain_signature_off", {22'h0, signature}, 32'h0);
`endif
    drain();

    // FIFO full and backpressure
    for (int i = 0; i < DEPTH_A; i++) send(20'($urandom), 1'b0, 1'b0);
    check("full_blocks_ready", {31'h0, stim_ready}, 32'h0);
    d9 = 20'($urandom);
    stim_valid = 1'b1;
    stim_data  = d9;
    repeat (3) tick();
    check("full_still_blocked", {31'h0, stim_ready}, 32'h0);
    check("full_no_capture", {16'h0, vec_count}, {16'h0, m_cnt});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("pop_reenables_ready", {31'h0, stim_ready}, 32'h1);
    send(d9, 1'b0, 1'b0);
    drain();

    // Push and pop on the same edge, with clr
    send(20'h12345, 1'b0, 1'b0);
    d9 = 20'hABCDE;
    send(d9, 1'b1, 1'b1);
    check("pp_res_valid", {31'h0, res_valid}, 32'h1);
    check("pp_res_data", {22'h0, res_data}, {22'h0, dut_model(d9)});
    check("pp_clr_signature", {22'h0, signature}, 32'h0);
    check("pp_clr_vec_count", {16'h0, vec_count}, 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("pp_count_was_one", {31'h0, res_valid}, 32'h0);

    // Randomized traffic with random pops and occasional clr
    rand_pop_en = 1'b1;
    for (int i = 0; i < 24; i++) send(20'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
    drain();

    // SETTLE=4 instance: capture timing, then reset mid-settle
    b_stim_valid = 1'b1;
    b_stim_data  = 20'h5A5A5;
    n = 0;
    while (!b_stim_ready && n < 20) begin tick(); n++; end
    check("b_ready", {31'h0, b_stim_ready}, 32'h1);
    tick();
    b_stim_valid = 1'b0;
    repeat (SETTLE_B - 1) tick();
    check("b_not_yet_captured", {31'h0, b_res_valid}, 32'h0);
    tick();
    check("b_res_valid", {31'h0, b_res_valid}, 32'h1);
    check("b_res_data", {22'h0, b_res_data}, {22'h0, dut_model(20'h5A5A5)});
    check("b_vec_count", {16'h0, b_vec_count}, 32'h1);
    check("b_signature", {22'h0, b_signature},
          {22'h0, exp_sig(misr_next(10'h000, dut_model(20'h5A5A5)))});
    b_stim_valid = 1'b1;
    b_stim_data  = 20'h0F0F0;
    n = 0;
    while (!b_stim_ready && n < 20) begin tick(); n++; end
    tick();
    b_stim_valid = 1'b0;
    repeat (2) tick();
    b_rst = 1'b1;
    #1;
    check("b_rst_dut_in", {12'h0, b_dut_in}, 32'h0);
    check("b_rst_busy", {31'h0, b_busy}, 32'h0);
    check("b_rst_fifo_empty", {31'h0, b_res_valid}, 32'h0);
    repeat (2) tick();
    b_rst = 1'b0;
    repeat (SETTLE_B + 2) tick();
    check("b_post_no_capture", {31'h0, b_res_valid}, 32'h0);
    check("b_post_vec_count", {16'h0, b_vec_count}, 32'h0);
    check("b_post_idle", {31'h0, b_busy}, 32'h0);
    check("b_post_dut_in", {12'h0, b_dut_in}, 32'h0);
    check("b_post_ready", {31'h0, b_stim_ready}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
